// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin share of the regfile write port.
// Ports: clk, rst (async high), stall, req_valid/addr/data in,
// req_ready one-hot grant out, waddr/wdata/wren registered to the
// regfile, grant_cnt per-requester counts when ARB_STATS_EN is defined.
module regfile_wr_arbiter #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        waddr,
  output logic [31:0]       wdata,
  output logic              wren
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

  // Parameter guard; an out-of-range build elaborates this empty block.
  if (NREQ < 2 || NREQ > 8 || CNT_W < 1) begin : g_bad_param
  end

  logic [PTR_W-1:0] r_ptr;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;
  logic             r_wren;

  logic             w_found;
  logic [PTR_W-1:0] w_gnt;
  logic [NREQ-1:0]  w_ready;
  logic [4:0]       w_addr;
  logic [31:0]      w_data;
  logic [PTR_W-1:0] w_ptr_nxt;
  int               w_j;

  // Search starts at r_ptr and wraps; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_found && !stall && req_valid[w_j]) begin
        w_found = 1'b1;
        w_gnt   = PTR_W'(w_j);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_found) w_ready[w_gnt] = 1'b1;
  end

  assign w_addr    = req_addr[int'(w_gnt)*5 +: 5];
  assign w_data    = req_data[int'(w_gnt)*32 +: 32];
  assign w_ptr_nxt = (w_gnt == LAST) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wren  <= 1'b0;
    end else begin
      if (w_found) begin
        r_ptr   <= w_ptr_nxt;
        r_waddr <= w_addr;
        r_wdata <= w_data;
        // x0 is accepted but never written
        r_wren  <= (w_addr != 5'd0);
      end else begin
        r_wren  <= 1'b0;
      end
    end
  end

  assign req_ready = w_ready;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign wren      = r_wren;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_found && int'(w_gnt) == i && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++)
      grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`endif

endmodule
